// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding (IEEE 1149.1 Table 6-3 codes),
// default instruction opcodes and IR length.
package jtag_pkg;

    localparam int         IR_WIDTH_DEF  = 4;
    localparam logic [3:0] OP_EXTEST_DEF = 4'h0;
    localparam logic [3:0] OP_SAMPLE_DEF = 4'h1;
    localparam logic [3:0] OP_BYPASS_DEF = 4'hF;

    typedef enum logic [3:0] {
        EXIT2_DR  = 4'h0,
        EXIT1_DR  = 4'h1,
        SHIFT_DR  = 4'h2,
        PAUSE_DR  = 4'h3,
        SEL_IR    = 4'h4,
        UPDATE_DR = 4'h5,
        CAP_DR    = 4'h6,
        SEL_DR    = 4'h7,
        EXIT2_IR  = 4'h8,
        EXIT1_IR  = 4'h9,
        SHIFT_IR  = 4'hA,
        PAUSE_IR  = 4'hB,
        RTI       = 4'hC,
        UPDATE_IR = 4'hD,
        CAP_IR    = 4'hE,
        TLR       = 4'hF
    } tap_state_t;

endpackage

// File: rtl/jtag_ir.sv
// Instruction register: capture/shift stage plus the applied (active) copy.
// The active copy falls back to BYPASS on reset or whenever the TAP enters TLR.
module jtag_ir
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH  = IR_WIDTH_DEF,
    parameter logic [IR_WIDTH-1:0] OP_BYPASS = '1
) (
    input  logic                i_tck,
    input  logic                i_reset,
    input  logic                i_capture,
    input  logic                i_shift,
    input  logic                i_update,
    input  logic                i_force_bypass,
    input  logic                i_tdi,
    output logic                o_ir_lsb,
    output logic [IR_WIDTH-1:0] o_ir_active
);

    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [IR_WIDTH-1:0] r_ir_active;

    always_ff @(posedge i_tck) begin
        if (i_reset) begin
            r_ir_shift <= '0;
        end else if (i_capture) begin
            r_ir_shift <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
        end else if (i_shift) begin
            r_ir_shift <= {i_tdi, r_ir_shift[IR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge i_tck) begin
        if (i_reset || i_force_bypass) begin
            r_ir_active <= OP_BYPASS;
        end else if (i_update) begin
            r_ir_active <= r_ir_shift;
        end
    end

    assign o_ir_lsb    = r_ir_shift[0];
    assign o_ir_active = r_ir_active;

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, bypass register, BSR strobe
// decode and TDO mux, sitting between the board TAP pins and the BSR chain.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH  = IR_WIDTH_DEF,
    parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(OP_EXTEST_DEF),
    parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(OP_SAMPLE_DEF),
    parameter logic [IR_WIDTH-1:0] OP_BYPASS = '1
) (
    input  logic                TCK,
    input  logic                Reset,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                bsr_tdo,
    output logic                bsr_tdi,
    output logic                ShiftDR,
    output logic                ClockDR,
    output logic                UpdateDR,
    output logic                Mode,
    output logic                TDO,
    output logic                tdo_en,
    output logic [IR_WIDTH-1:0] ir_active,
    output logic [3:0]          tap_state
);

    // state            | meaning
    // TLR / RTI        | test-logic-reset / run-test-idle
    // SEL_DR / SEL_IR  | choose DR or IR scan branch
    // CAP_DR / CAP_IR  | parallel capture into the selected register
    // SHIFT_DR/SHIFT_IR| serial shift TDI -> TDO
    // EXIT1_x / EXIT2_x| leave shift or pause
    // PAUSE_x          | hold contents, no shifting
    // UPDATE_x         | apply shifted value

    tap_state_t r_state;
    tap_state_t w_state_nxt;
    logic       r_bypass;
    logic       w_bsr_sel;
    logic       w_ir_lsb;

    always_ff @(posedge TCK) begin
        if (Reset) begin
            r_state <= TLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TLR:       w_state_nxt = TMS ? TLR       : RTI;
            RTI:       w_state_nxt = TMS ? SEL_DR    : RTI;
            SEL_DR:    w_state_nxt = TMS ? SEL_IR    : CAP_DR;
            CAP_DR:    w_state_nxt = TMS ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:  w_state_nxt = TMS ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:  w_state_nxt = TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:  w_state_nxt = TMS ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:  w_state_nxt = TMS ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR: w_state_nxt = TMS ? SEL_DR    : RTI;
            SEL_IR:    w_state_nxt = TMS ? TLR       : CAP_IR;
            CAP_IR:    w_state_nxt = TMS ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:  w_state_nxt = TMS ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:  w_state_nxt = TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:  w_state_nxt = TMS ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:  w_state_nxt = TMS ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR: w_state_nxt = TMS ? SEL_DR    : RTI;
            default:   w_state_nxt = TLR;
        endcase

        // Strobes and TDO come only from registered state, so they never glitch on TMS.
        ShiftDR  = w_bsr_sel && (r_state == SHIFT_DR);
        ClockDR  = w_bsr_sel && ((r_state == CAP_DR) || (r_state == SHIFT_DR));
        UpdateDR = w_bsr_sel && (r_state == UPDATE_DR);
        tdo_en   = (r_state == SHIFT_DR) || (r_state == SHIFT_IR);
        TDO      = 1'b0;
        if (r_state == SHIFT_IR) begin
            TDO = w_ir_lsb;
        end else if (r_state == SHIFT_DR) begin
            TDO = w_bsr_sel ? bsr_tdo : r_bypass;
        end
    end

    always_ff @(posedge TCK) begin
        if (Reset || (r_state == CAP_DR)) begin
            r_bypass <= 1'b0;
        end else if (r_state == SHIFT_DR) begin
            r_bypass <= TDI;
        end
    end

    jtag_ir #(
        .IR_WIDTH  (IR_WIDTH),
        .OP_BYPASS (OP_BYPASS)
    ) u_ir (
        .i_tck          (TCK),
        .i_reset        (Reset),
        .i_capture      (r_state == CAP_IR),
        .i_shift        (r_state == SHIFT_IR),
        .i_update       (r_state == UPDATE_IR),
        .i_force_bypass (w_state_nxt == TLR),
        .i_tdi          (TDI),
        .o_ir_lsb       (w_ir_lsb),
        .o_ir_active    (ir_active)
    );

    assign w_bsr_sel = (ir_active == OP_EXTEST) || (ir_active == OP_SAMPLE);
    assign Mode      = (ir_active == OP_EXTEST);
    assign bsr_tdi   = TDI;
    assign tap_state = r_state;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Scoreboard bench for jtag_tap_controller: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_jtag_tap_controller;
    import jtag_pkg::*;

    logic       TCK = 1'b0;
    logic       Reset = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       bsr_tdo;
    logic       bsr_tdi;
    logic       ShiftDR, ClockDR, UpdateDR, Mode, TDO, tdo_en;
    logic [3:0] ir_active;
    logic [3:0] tap_state;

    always #5 TCK = ~TCK;

    jtag_tap_controller dut (
        .TCK       (TCK),
        .Reset     (Reset),
        .TMS       (TMS),
        .TDI       (TDI),
        .bsr_tdo   (bsr_tdo),
        .bsr_tdi   (bsr_tdi),
        .ShiftDR   (ShiftDR),
        .ClockDR   (ClockDR),
        .UpdateDR  (UpdateDR),
        .Mode      (Mode),
        .TDO       (TDO),
        .tdo_en    (tdo_en),
        .ir_active (ir_active),
        .tap_state (tap_state)
    );

    // Three-cell boundary-scan chain; pins captured as p0=1, p1=0, p2=1.
    localparam logic [2:0] PINS = 3'b101;
    logic [2:0] r_cell = 3'b000;
    always @(posedge TCK) begin
        if (ClockDR) begin
            if (ShiftDR) r_cell <= {r_cell[1:0], bsr_tdi};
            else         r_cell <= PINS;
        end
    end
    assign bsr_tdo = r_cell[2];

    typedef struct {
        int         lvl;   // 0 none, 1 state only, 2 all outputs
        int         test;
        logic [3:0] st;
        logic [2:0] sdu;   // {ShiftDR, ClockDR, UpdateDR}
        logic       en;
        logic       tdo;
        logic [3:0] ir;
        logic       mode;
    } exp_t;

    localparam logic [2:0] N   = 3'b000;
    localparam logic [2:0] CAP = 3'b010;
    localparam logic [2:0] SH  = 3'b110;
    localparam logic [2:0] UPD = 3'b001;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         g_test = 0;
    logic [3:0] g_ir = 4'hF;
    logic       g_mode = 1'b0;

    task automatic tick(input logic rst, input logic tms, input logic tdi, input int lvl,
                        input logic [3:0] st, input logic [2:0] sdu, input logic en,
                        input logic tdo);
        exp_t e;
        Reset = rst;
        TMS   = tms;
        TDI   = tdi;
        @(posedge TCK);
        #1;
        e.lvl = lvl; e.test = g_test; e.st = st; e.sdu = sdu; e.en = en; e.tdo = tdo;
        e.ir = g_ir; e.mode = g_mode;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int tid, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL t%0d %s: got %0h want %0h (time %0t)", tid, nm, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge TCK);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.lvl >= 1) chk("tap_state", e.test, {4'h0, tap_state}, {4'h0, e.st});
                if (e.lvl >= 2) begin
                    chk("ShiftDR",   e.test, {7'h0, ShiftDR},  {7'h0, e.sdu[2]});
                    chk("ClockDR",   e.test, {7'h0, ClockDR},  {7'h0, e.sdu[1]});
                    chk("UpdateDR",  e.test, {7'h0, UpdateDR}, {7'h0, e.sdu[0]});
                    chk("tdo_en",    e.test, {7'h0, tdo_en},   {7'h0, e.en});
                    chk("TDO",       e.test, {7'h0, TDO},      {7'h0, e.tdo});
                    chk("ir_active", e.test, {4'h0, ir_active}, {4'h0, e.ir});
                    chk("Mode",      e.test, {7'h0, Mode},     {7'h0, e.mode});
                end
            end
        end
    end

    // DR scan with the bypass register selected: TDI 1,0,1,1 -> TDO 0,1,0,1.
    task automatic bypass_scan();
        tick(0, 1, 0, 2, SEL_DR,    N, 0, 0);
        tick(0, 0, 0, 2, CAP_DR,    N, 0, 0);
        tick(0, 0, 0, 2, SHIFT_DR,  N, 1, 0);
        tick(0, 0, 1, 2, SHIFT_DR,  N, 1, 1);
        tick(0, 0, 0, 2, SHIFT_DR,  N, 1, 0);
        tick(0, 0, 1, 2, SHIFT_DR,  N, 1, 1);
        tick(0, 1, 1, 2, EXIT1_DR,  N, 0, 0);
        tick(0, 1, 0, 2, UPDATE_DR, N, 0, 0);
        tick(0, 0, 0, 2, RTI,       N, 0, 0);
    endtask

    string      paths[16] = '{"", "0", "01", "010", "0100", "0101", "01010", "010101",
                              "01011", "011", "0110", "01100", "01101", "011010",
                              "0110101", "011011"};
    logic [3:0] tgts[16]  = '{TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR,
                              EXIT2_DR, UPDATE_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR,
                              PAUSE_IR, EXIT2_IR, UPDATE_IR};

    initial begin
        logic [7:0] d3;
        logic [7:0] e3;
        d3 = 8'b0100_1011;  // TDI bits, bit0 first
        e3 = 8'b0101_1101;  // TDO in the 8 Shift-DR cycles, bit0 first

        // 1: reset, then five TMS=1 from every state
        g_test = 1;
        tick(1, 1, 0, 2, TLR, N, 0, 0);
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < paths[i].len(); j++) begin
                tick(0, paths[i][j] == 8'h31, 0, (j == paths[i].len() - 1) ? 1 : 0,
                     tgts[i], N, 0, 0);
            end
            for (int k = 0; k < 5; k++) tick(0, 1, 0, (k == 4) ? 2 : 0, TLR, N, 0, 0);
        end

        // 2: load EXTEST (4'h0) through the IR
        g_test = 2;
        tick(0, 0, 0, 2, RTI,       N, 0, 0);
        tick(0, 1, 0, 2, SEL_DR,    N, 0, 0);
        tick(0, 1, 0, 2, SEL_IR,    N, 0, 0);
        tick(0, 0, 0, 2, CAP_IR,    N, 0, 0);
        tick(0, 0, 0, 2, SHIFT_IR,  N, 1, 1);
        tick(0, 0, 0, 2, SHIFT_IR,  N, 1, 0);
        tick(0, 0, 0, 2, SHIFT_IR,  N, 1, 0);
        tick(0, 0, 0, 2, SHIFT_IR,  N, 1, 0);
        tick(0, 1, 0, 2, EXIT1_IR,  N, 0, 0);
        tick(0, 1, 0, 2, UPDATE_IR, N, 0, 0);
        g_ir = 4'h0; g_mode = 1'b1;
        tick(0, 0, 0, 2, RTI,       N, 0, 0);

        // 3: EXTEST 8-bit DR scan through the 3-cell chain
        g_test = 3;
        tick(0, 1, 0, 2, SEL_DR,   N,   0, 0);
        tick(0, 0, 0, 2, CAP_DR,   CAP, 0, 0);
        tick(0, 0, 0, 2, SHIFT_DR, SH,  1, e3[0]);
        for (int k = 0; k < 7; k++) tick(0, 0, d3[k], 2, SHIFT_DR, SH, 1, e3[k+1]);
        tick(0, 1, d3[7], 2, EXIT1_DR,  N,   0, 0);
        tick(0, 1, 0,     2, UPDATE_DR, UPD, 0, 0);
        tick(0, 0, 0,     2, RTI,       N,   0, 0);

        // 5: Pause-DR for 3 cycles mid-shift
        g_test = 5;
        tick(0, 1, 0, 2, SEL_DR,    N,   0, 0);
        tick(0, 0, 0, 2, CAP_DR,    CAP, 0, 0);
        tick(0, 0, 0, 2, SHIFT_DR,  SH,  1, 1);
        tick(0, 0, 0, 2, SHIFT_DR,  SH,  1, 0);
        tick(0, 1, 1, 2, EXIT1_DR,  N,   0, 0);
        tick(0, 0, 0, 2, PAUSE_DR,  N,   0, 0);
        tick(0, 0, 0, 2, PAUSE_DR,  N,   0, 0);
        tick(0, 0, 0, 2, PAUSE_DR,  N,   0, 0);
        tick(0, 1, 0, 2, EXIT2_DR,  N,   0, 0);
        tick(0, 0, 0, 2, SHIFT_DR,  SH,  1, 1);
        tick(0, 0, 0, 2, SHIFT_DR,  SH,  1, 0);
        tick(0, 1, 0, 2, EXIT1_DR,  N,   0, 0);
        tick(0, 1, 0, 2, UPDATE_DR, UPD, 0, 0);
        tick(0, 0, 0, 2, RTI,       N,   0, 0);

        // 6: reset during Shift-IR after two bits
        g_test = 6;
        tick(0, 1, 0, 2, SEL_DR,   N, 0, 0);
        tick(0, 1, 0, 2, SEL_IR,   N, 0, 0);
        tick(0, 0, 0, 2, CAP_IR,   N, 0, 0);
        tick(0, 0, 0, 2, SHIFT_IR, N, 1, 1);
        tick(0, 0, 1, 2, SHIFT_IR, N, 1, 0);
        tick(0, 0, 0, 2, SHIFT_IR, N, 1, 0);
        g_ir = 4'hF; g_mode = 1'b0;
        tick(1, 0, 0, 2, TLR,      N, 0, 0);

        // 4: BYPASS DR scan, then unknown opcode 4'h5 must behave the same
        g_test = 4;
        tick(0, 0, 0, 2, RTI, N, 0, 0);
        bypass_scan();
        tick(0, 1, 0, 2, SEL_DR,    N, 0, 0);
        tick(0, 1, 0, 2, SEL_IR,    N, 0, 0);
        tick(0, 0, 0, 2, CAP_IR,    N, 0, 0);
        tick(0, 0, 0, 2, SHIFT_IR,  N, 1, 1);
        tick(0, 0, 1, 2, SHIFT_IR,  N, 1, 0);
        tick(0, 0, 0, 2, SHIFT_IR,  N, 1, 0);
        tick(0, 0, 1, 2, SHIFT_IR,  N, 1, 0);
        tick(0, 1, 0, 2, EXIT1_IR,  N, 0, 0);
        tick(0, 1, 0, 2, UPDATE_IR, N, 0, 0);
        g_ir = 4'h5;
        tick(0, 0, 0, 2, RTI,       N, 0, 0);
        g_test = 7;
        bypass_scan();

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge TCK);
        @(posedge TCK);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
